// File: rtl/edge_detector_multi.sv
// edge_detector_multi: CH independent edge detectors with registered one-cycle
// pulses, a shared edge-mode select and per-channel saturating counters.
// Optional feature macro: EDGE_DEBOUNCE_EN adds a per-channel stability filter
// that accepts a level change only after DEB_CYC consecutive samples.
module edge_detector_multi #(
  parameter int CH      = 4,
  parameter int CW      = 8,
  parameter int DEB_CYC = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CH-1:0]    eisodos,
  input  logic [1:0]       mode,
  input  logic             clr,
  output logic [CH-1:0]    eksodos,
  output logic             any_edge,
  output logic [CH*CW-1:0] count
);

  typedef enum logic [1:0] {
    UNPRIMED = 2'd0,
    LOW      = 2'd1,
    HIGH     = 2'd2
  } state_t;

  state_t        state      [CH];
  state_t        state_next [CH];
  logic [CH-1:0] rise;
  logic [CH-1:0] fall;
  logic [CH-1:0] qual;
  logic          rise_en;
  logic          fall_en;
  logic [CW-1:0] cnt [CH];

  // Reject out-of-range parameters at elaboration time.
  if (CH < 1 || CH > 32) begin : g_bad_ch
    $error("edge_detector_multi: CH must be in 1..32");
  end
  if (CW < 2 || CW > 16) begin : g_bad_cw
    $error("edge_detector_multi: CW must be in 2..16");
  end
  if (DEB_CYC < 2 || DEB_CYC > 15) begin : g_bad_deb
    $error("edge_detector_multi: DEB_CYC must be in 2..15");
  end

  assign rise_en = (mode == 2'b00) || (mode == 2'b10);
  assign fall_en = (mode == 2'b01) || (mode == 2'b10);

`ifdef EDGE_DEBOUNCE_EN
  localparam logic [3:0] DEB_LAST = 4'(DEB_CYC - 1);

  logic [3:0] stab      [CH];
  logic [3:0] stab_next [CH];

  // Level tracking with debounce: a new level must persist for DEB_CYC samples.
  always_comb begin
    for (int i = 0; i < CH; i++) begin
      state_next[i] = state[i];
      stab_next[i]  = 4'd0;
      rise[i]       = 1'b0;
      fall[i]       = 1'b0;
      case (state[i])
        UNPRIMED: state_next[i] = eisodos[i] ? HIGH : LOW;
        LOW: begin
          if (eisodos[i]) begin
            if (stab[i] == DEB_LAST) begin
              state_next[i] = HIGH;
              rise[i]       = 1'b1;
            end else begin
              stab_next[i] = stab[i] + 4'd1;
            end
          end
        end
        HIGH: begin
          if (!eisodos[i]) begin
            if (stab[i] == DEB_LAST) begin
              state_next[i] = LOW;
              fall[i]       = 1'b1;
            end else begin
              stab_next[i] = stab[i] + 4'd1;
            end
          end
        end
        default: state_next[i] = UNPRIMED;
      endcase
    end
  end

  // Stability counters restart whenever the input agrees with the tracked level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CH; i++) stab[i] <= 4'd0;
    end else begin
      for (int i = 0; i < CH; i++) stab[i] <= stab_next[i];
    end
  end
`else
  // Level tracking: every change of a primed channel is an edge.
  always_comb begin
    for (int i = 0; i < CH; i++) begin
      state_next[i] = state[i];
      rise[i]       = 1'b0;
      fall[i]       = 1'b0;
      case (state[i])
        UNPRIMED: state_next[i] = eisodos[i] ? HIGH : LOW;
        LOW: begin
          if (eisodos[i]) begin
            state_next[i] = HIGH;
            rise[i]       = 1'b1;
          end
        end
        HIGH: begin
          if (!eisodos[i]) begin
            state_next[i] = LOW;
            fall[i]       = 1'b1;
          end
        end
        default: state_next[i] = UNPRIMED;
      endcase
    end
  end
`endif

  // Mode gating; level tracking above continues even when nothing qualifies.
  always_comb begin
    qual = (rise & {CH{rise_en}}) | (fall & {CH{fall_en}});
  end

  // Per-channel state registers; reset forces re-priming from the next sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CH; i++) state[i] <= UNPRIMED;
    end else begin
      for (int i = 0; i < CH; i++) state[i] <= state_next[i];
    end
  end

  // Saturating edge counters; clear has priority over a coincident edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CH; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < CH; i++) begin
        if (clr) begin
          cnt[i] <= '0;
        end else if (qual[i] && (cnt[i] != {CW{1'b1}})) begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  // Registered pulses and their OR, both updated on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      eksodos  <= '0;
      any_edge <= 1'b0;
    end else begin
      eksodos  <= qual;
      any_edge <= |qual;
    end
  end

  for (genvar g = 0; g < CH; g++) begin : g_count
    assign count[g*CW +: CW] = cnt[g];
  end

endmodule

// File: doc/edge_detector_multi.md
# edge_detector_multi

Parametrised multi-channel edge detector with registered one-cycle pulse outputs, selectable edge mode and per-channel saturating edge counters. It generalises the single-input edge-dependent FSM to CH independent channels. It sits between raw synchronous control inputs and downstream counters or interrupt logic.

## Interface
- CH, 4, number of independent input channels (1..32)
- CW, 8, width of each per-channel edge counter (2..16)
- DEB_CYC, 3, stable-sample count required by the debounce filter (2..15; used only with EDGE_DEBOUNCE_EN)
- clk  input  1  single system clock; all state updates on posedge
- rst  input  1  asynchronous, active-high reset
- eisodos  input  CH  channel inputs; synchronous to clk
- mode  input  2  00 rising, 01 falling, 10 both edges, 11 detection disabled
- clr  input  1  synchronous clear of all counters
- eksodos  output  CH  per-channel edge pulse, registered, one cycle wide
- any_edge  output  1  registered OR of all eksodos bits (same cycle as eksodos)
- count  output  CH*CW  packed counters; channel i at bits [i*CW +: CW]

## Operation
- Per-channel FSM, 3 states: UNPRIMED, LOW, HIGH.
  - UNPRIMED: entered on reset. On the first posedge after reset, go to HIGH if eisodos[i]=1, else LOW. No pulse, no count.
  - LOW: eisodos[i]=1 -> HIGH, rising edge detected. Else stay.
  - HIGH: eisodos[i]=0 -> LOW, falling edge detected. Else stay.
- Qualification by mode: rising qualifies in 00/10, falling qualifies in 01/10, nothing qualifies in 11. The FSM still tracks the level in mode 11.
- Qualified edge: eksodos[i]<=1 for exactly one cycle, and count[i] increments.
- Counter saturates at 2^CW-1. Further edges still pulse eksodos but leave the count unchanged.
- clr: all counters <=0 on that posedge. If clr and a qualified edge coincide, clr wins (count=0), but eksodos still pulses. clr does not affect FSM state.
- A mode change takes effect on the same posedge it is sampled. FSM level history is kept, so no spurious edge appears.
- Channels are fully independent. Simultaneous edges on several channels all report in the same cycle.

## Timing
- Reset values: eksodos=0, any_edge=0, all counts=0, all FSMs UNPRIMED.
- Latency without debounce: an input change sampled at posedge n gives eksodos high during cycle n+1 (after posedge n) and count updated after posedge n.
- Input toggling every cycle in mode 10: eksodos stays high continuously, and the count increments every cycle.
- Reset asserted mid-operation: all outputs clear immediately (asynchronous). On deassertion, channels re-prime, so a level already high at release is not an edge.
- any_edge is registered alongside eksodos, not derived combinationally from it.

## Configuration
- EDGE_DEBOUNCE_EN defined: each channel gets a filter with a CW-independent 4-bit stability counter.
  - A level change is accepted only after eisodos[i] has held the new value for DEB_CYC consecutive samples.
  - The accepted edge pulses on the posedge that completes the run, so latency is DEB_CYC cycles from the first new-value sample.
  - Any reversion before completion resets the stability counter without a pulse.
  - UNPRIMED also primes from the first sample, without filtering.
- EDGE_DEBOUNCE_EN undefined: no filter logic is present, behaviour is as described above, and DEB_CYC is ignored.

## Test plan
- Reset with eisodos=4'b1111, then release: eksodos stays 0 and counts stay 0 for 5 cycles. Then drive ch0 to 0 in mode 01: eksodos=4'b0001 for one cycle and count0=1.
- Mode 00 with ch2 toggled 0->1->0->1 at 3-cycle spacing: 2 pulses, count2=2. Repeat in mode 10: 3 pulses, count2=5.
- CW=2 with 5 rising edges on ch1: count1 saturates at 3, and eksodos[1] pulses all 5 times.
- clr asserted on the same cycle as a rising edge on ch3 with count3=7: the next cycle shows count3=0 and eksodos[3]=1. Mode 11 with toggling inputs: no pulses and counts unchanged.
- Assert rst mid-pulse, asynchronously between edges: eksodos, any_edge and counts drop to 0 before the next posedge.
- With EDGE_DEBOUNCE_EN and DEB_CYC=3: a 2-cycle high glitch on ch0 gives no pulse. A 3-cycle-stable high gives one pulse 3 cycles after the first high sample.
